// File: rtl/magnitude_search.sv
// ============================================================================
// Module   : magnitude_search
// Brief    : Successive-approximation search that drives a magnitude
//            comparator's B operand and recovers the value on its A operand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module magnitude_search #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [WIDTH-1:0]   c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_msb      = c_one << (WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_trial,  w_trial_nxt;
    logic [c_idx_w-1:0] r_idx,    w_idx_nxt;
    logic [c_cnt_w-1:0] r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0]   r_guess,  w_guess_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_done,   w_done_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_err,    w_err_nxt;

    logic [1:0]         w_flag_cnt;
    logic [WIDTH-1:0]   w_trial_upd;
    logic [c_idx_w-1:0] w_idx_dec;
    logic               w_finish;

    assign w_flag_cnt  = {1'b0, lt} + {1'b0, eq} + {1'b0, gt};
    // gt means the target is above the guess, so the trial bit survives
    assign w_trial_upd = gt ? r_guess : r_trial;
    assign w_idx_dec   = r_idx - c_idx_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_trial  <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_guess  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_guess  <= w_guess_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_guess_nxt  = r_guess;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        w_finish     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_trial_nxt = '0;
                    w_idx_nxt   = c_idx_top;
                    w_guess_nxt = c_msb;
                    w_cnt_nxt   = c_cnt_init;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (w_flag_cnt != 2'd1) begin
                    w_err_nxt    = 1'b1;
                    w_result_nxt = r_guess;
                    w_finish     = 1'b1;
                end else if (eq) begin
                    w_result_nxt = r_guess;
                    w_finish     = 1'b1;
                end else begin
                    w_trial_nxt = w_trial_upd;
                    if (r_idx == '0) begin
                        w_result_nxt = w_trial_upd;
                        w_finish     = 1'b1;
                    end else begin
                        w_idx_nxt   = w_idx_dec;
                        w_guess_nxt = w_trial_upd | (c_one << w_idx_dec);
                        w_cnt_nxt   = c_cnt_init;
                    end
                end
            end
        endcase

        if (w_finish) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_guess_nxt = '0;
            w_state_nxt = ST_IDLE;
        end
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;

endmodule

`default_nettype wire
